bf_bus_arbiter: RTL and testbench
=================================

// Module: bf_bus_arbiter
// PURPOSE
//   Shares one single-port sync SRAM (program + data spaces) and one byte-stream I/O channel
//   between the BF interpreter core and a host loader/debug port. Sequences every bus cycle.
//   Returns a one-cycle valid strobe that stalls the core until its access completes.
//   Sits between the core bus strobes and the physical memory / UART-style I/O.
// PARAMETERS
//   ADDR_WIDTH  15  core/host address width per space; SRAM address is ADDR_WIDTH+1 bits
//   DATA_WIDTH   8  data / I/O word width
// PORTS
//   clock         in   1    system clock, all state on rising edge
//   reset         in   1    synchronous, active-high
//   core_addr     in   AW   core address (pc or cursor)
//   core_wdata    in   DW   core write data (val_out)
//   read_prog     in   1    core strobe: program read
//   read_data     in   1    core strobe: data read
//   write_data    in   1    core strobe: data write
//   read_io       in   1    core strobe: input byte
//   write_io      in   1    core strobe: output byte
//   core_rdata    out  DW   registered read data to core (val_in)
//   core_valid    out  1    1-cycle pulse: core access complete
//   host_req      in   1    host request, held until host_ack
//   host_we       in   1    host write (1) / read (0)
//   host_space    in   1    0 = program space, 1 = data space
//   host_addr     in   AW   host address
//   host_wdata    in   DW   host write data
//   host_rdata    out  DW   registered host read data
//   host_ack      out  1    1-cycle pulse: host access complete
//   mem_en        out  1    SRAM enable; read data valid next cycle
//   mem_we        out  1    SRAM write enable
//   mem_addr      out  AW+1 {space, addr}; space 0 = program, 1 = data
//   mem_wdata     out  DW   SRAM write data
//   mem_rdata     in   DW   SRAM read data, 1 cycle after mem_en & !mem_we
//   io_out_data   out  DW   output byte
//   io_out_valid  out  1    output valid, held until io_out_ready
//   io_out_ready  in   1    sink accepts
//   io_in_data    in   DW   input byte
//   io_in_valid   in   1    source has byte
//   io_in_ready   out  1    arbiter accepts input, held until io_in_valid
//   busy          out  1    state != IDLE
//   bus_err       out  1    sticky: >1 core strobe asserted at a grant
// BEHAVIOUR
//   Reset: state IDLE; every output 0; rr pointer = HOST (host wins first tie).
//   FSM: IDLE, MEM_WAIT, IO_RD, IO_WR, DONE.
//   IDLE: core request = OR of five strobes. One requester -> grant it; both -> rr pointer;
//     pointer flips to the other requester on each grant. Grant cycle issues the access.
//     Mem read: mem_en=1, addr driven combinationally -> MEM_WAIT.
//     Mem write: mem_en=mem_we=1 -> DONE.
//     Core I/O -> IO_RD / IO_WR. Host never accesses I/O.
//   Core strobe priority: read_prog > read_data > write_data > read_io > write_io.
//     More than one strobe at a grant: serve the highest, set bus_err (cleared only by reset).
//   Core read_prog -> space 0; read_data/write_data -> space 1; host uses host_space.
//   MEM_WAIT: capture mem_rdata into the winner's rdata register -> DONE.
//   IO_WR: io_out_valid=1, io_out_data=latched core_wdata, held stable.
//     On io_out_ready -> DONE.
//   IO_RD: io_in_ready=1. On io_in_valid capture io_in_data into core_rdata -> DONE.
//   DONE: pulse winner's core_valid or host_ack for exactly one cycle; requests ignored.
//     Then return to IDLE. Requesters drop or change their request in the valid/ack cycle.
//   Latency grant->valid: mem read 2 cycles, mem write 1 cycle; I/O 1 cycle after handshake.
//     Back-to-back grant spacing is 3 (read) or 2 (write) cycles.
//   rdata registers hold their last value until the next capture.
//   Request inputs and addresses are sampled only in IDLE and latched at grant.
//     Later changes have no effect until DONE.
//   Reset mid-operation: abandon the transaction. Next cycle in IDLE with all strobes 0.
//     No valid/ack issued; the I/O byte is not consumed or emitted.
//   Address wrap: none; the full AW range is legal (0x7FFF data -> mem_addr 0xFFFF).
// TESTING
//   1. prog[0x0010]=0x2B; core read_prog addr 0x0010 -> mem_addr=0x00010 in grant cycle;
//      core_valid 2 cycles later with core_rdata=0x2B.
//   2. After reset, core write_data and host read held together -> host acked first, then core.
//      Continuous requests alternate grants over 4 pairs.
//   3. write_io 0x41, io_out_ready low 5 cycles -> io_out_valid=1 and data 0x41 stable;
//      core_valid 1 cycle after ready.
//   4. read_data and write_data together, addr 0x0003 -> read of data[3] only;
//      no mem_we; bus_err=1 and stays 1 until reset.
//   5. reset asserted during IO_RD -> next cycle io_in_ready=0, busy=0;
//      no core_valid; later io_in byte waits.
//   6. host write space 1, addr 0x7FFF, data 0xA5 -> mem_addr=0xFFFF, mem_we=1;
//      host_ack next cycle; a core read_data of 0x7FFF then returns 0xA5.

Source files
------------

// File: rtl/bf_bus_arbiter.sv
// bf_bus_arbiter: sequences every bus cycle of the BF core and the host
// loader/debug port onto one single-port sync SRAM and one byte-stream I/O
// channel. Core and host are arbitrated round-robin. Each completed access
// returns a one-cycle core_valid / host_ack strobe.
module bf_bus_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    input  logic                  i_read_prog,
    input  logic                  i_read_data,
    input  logic                  i_write_data,
    input  logic                  i_read_io,
    input  logic                  i_write_io,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    output logic                  o_core_valid,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic                  i_host_space,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_ack,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_io_out_data,
    output logic                  o_io_out_valid,
    input  logic                  i_io_out_ready,
    input  logic [DATA_WIDTH-1:0] i_io_in_data,
    input  logic                  i_io_in_valid,
    output logic                  o_io_in_ready,
    output logic                  o_busy,
    output logic                  o_bus_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_IO_RD,
        S_IO_WR,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_rr_host;   // 1: host wins the next tie
    logic                  r_win_host;  // owner of the transaction in flight
    logic [DATA_WIDTH-1:0] r_core_rdata;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic                  r_core_valid;
    logic                  r_host_ack;
    logic [DATA_WIDTH-1:0] r_io_out_data;
    logic                  r_io_out_valid;
    logic                  r_io_in_ready;
    logic                  r_bus_err;

    // Strobe vector, bit 0 is the highest priority (read_prog).
    logic [4:0] w_strb;
    logic [4:0] w_sel;
    logic       w_multi;
    logic       w_idle;
    logic       w_core_req;
    logic       w_gnt_host;
    logic       w_gnt_core;
    logic       w_core_mem;

    assign w_strb     = {i_write_io, i_read_io, i_write_data, i_read_data, i_read_prog};
    assign w_multi    = |(w_strb & (w_strb - 5'd1));
    assign w_core_req = |w_strb;
    // Combinational bus outputs are suppressed while reset is held so every
    // output reads 0 during reset regardless of the request inputs.
    assign w_idle     = (r_state == S_IDLE) && !i_reset;
    assign w_gnt_host = w_idle && i_host_req && (!w_core_req || r_rr_host);
    assign w_gnt_core = w_idle && w_core_req && (!i_host_req || !r_rr_host);
    assign w_core_mem = |w_sel[2:0];

    // Fixed-priority pick of a single core strobe.
    always_comb begin
        w_sel = 5'b0;
        if (i_read_prog)       w_sel[0] = 1'b1;
        else if (i_read_data)  w_sel[1] = 1'b1;
        else if (i_write_data) w_sel[2] = 1'b1;
        else if (i_read_io)    w_sel[3] = 1'b1;
        else if (i_write_io)   w_sel[4] = 1'b1;
    end

    // Grant-cycle SRAM access, driven straight from the winner's inputs.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt_host) begin
            o_mem_en   = 1'b1;
            o_mem_we   = i_host_we;
            o_mem_addr = {i_host_space, i_host_addr};
            if (i_host_we) o_mem_wdata = i_host_wdata;
        end else if (w_gnt_core && w_core_mem) begin
            o_mem_en   = 1'b1;
            o_mem_we   = w_sel[2];
            o_mem_addr = {~w_sel[0], i_core_addr};
            if (w_sel[2]) o_mem_wdata = i_core_wdata;
        end
    end

    // Bus sequencer: grant, wait for memory / I/O handshake, strobe completion.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_rr_host      <= 1'b1;
            r_win_host     <= 1'b0;
            r_core_rdata   <= '0;
            r_host_rdata   <= '0;
            r_core_valid   <= 1'b0;
            r_host_ack     <= 1'b0;
            r_io_out_data  <= '0;
            r_io_out_valid <= 1'b0;
            r_io_in_ready  <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_core_valid <= 1'b0;
            r_host_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_host) begin
                        r_rr_host  <= 1'b0;
                        r_win_host <= 1'b1;
                        if (i_host_we) begin
                            r_host_ack <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state    <= S_MEM_WAIT;
                        end
                    end else if (w_gnt_core) begin
                        r_rr_host  <= 1'b1;
                        r_win_host <= 1'b0;
                        if (w_multi) r_bus_err <= 1'b1;
                        if (w_sel[0] || w_sel[1]) begin
                            r_state <= S_MEM_WAIT;
                        end else if (w_sel[2]) begin
                            r_core_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else if (w_sel[3]) begin
                            r_io_in_ready <= 1'b1;
                            r_state       <= S_IO_RD;
                        end else begin
                            r_io_out_valid <= 1'b1;
                            r_io_out_data  <= i_core_wdata;
                            r_state        <= S_IO_WR;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (r_win_host) begin
                        r_host_rdata <= i_mem_rdata;
                        r_host_ack   <= 1'b1;
                    end else begin
                        r_core_rdata <= i_mem_rdata;
                        r_core_valid <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_IO_RD: begin
                    if (i_io_in_valid) begin
                        r_core_rdata  <= i_io_in_data;
                        r_io_in_ready <= 1'b0;
                        r_core_valid  <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_IO_WR: begin
                    if (i_io_out_ready) begin
                        r_io_out_valid <= 1'b0;
                        r_core_valid   <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_core_rdata   = r_core_rdata;
    assign o_core_valid   = r_core_valid;
    assign o_host_rdata   = r_host_rdata;
    assign o_host_ack     = r_host_ack;
    assign o_io_out_data  = r_io_out_data;
    assign o_io_out_valid = r_io_out_valid;
    assign o_io_in_ready  = r_io_in_ready;
    assign o_busy         = (r_state != S_IDLE);
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_bf_bus_arbiter.sv
// Directed bench for bf_bus_arbiter with a behavioural SRAM and a scoreboard
// of expected completions (owner + read data) popped on each valid/ack.
module tb_bf_bus_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          read_prog, read_data, write_data, read_io, write_io;
    logic [DW-1:0] core_rdata;
    logic          core_valid;
    logic          host_req, host_we, host_space;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          mem_en, mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] io_out_data;
    logic          io_out_valid, io_out_ready;
    logic [DW-1:0] io_in_data;
    logic          io_in_valid, io_in_ready;
    logic          busy, bus_err;

    typedef struct {
        logic          host;
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bf_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .i_read_prog(read_prog), .i_read_data(read_data), .i_write_data(write_data),
        .i_read_io(read_io), .i_write_io(write_io),
        .o_core_rdata(core_rdata), .o_core_valid(core_valid),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_space(host_space),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_rdata(host_rdata), .o_host_ack(host_ack),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_io_out_data(io_out_data), .o_io_out_valid(io_out_valid), .i_io_out_ready(io_out_ready),
        .i_io_in_data(io_in_data), .i_io_in_valid(io_in_valid), .o_io_in_ready(io_in_ready),
        .o_busy(busy), .o_bus_err(bus_err)
    );

    // Single-port synchronous SRAM, read data one cycle after enable.
    logic [DW-1:0] sram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic host, input logic c, input logic [DW-1:0] d);
        exp_t e;
        e.host = host; e.chk = c; e.data = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_core();
        read_prog = 0; read_data = 0; write_data = 0; read_io = 0; write_io = 0;
    endtask

    task automatic wait_done(input logic host, input string tag);
        int n = 0;
        while (!(host ? host_ack : core_valid) && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 40), 32'd1);
    endtask

    task automatic core_op(input logic [4:0] strb, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic c, input logic [DW-1:0] d, input string tag);
        push(1'b0, c, d);
        {write_io, read_io, write_data, read_data, read_prog} = strb;
        core_addr = a; core_wdata = wd;
        wait_done(1'b0, tag);
        clr_core();
        step();
    endtask

    task automatic host_op(input logic we, input logic sp, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic c, input logic [DW-1:0] d,
                           input string tag);
        push(1'b1, c, d);
        host_req = 1; host_we = we; host_space = sp; host_addr = a; host_wdata = wd;
        wait_done(1'b1, tag);
        host_req = 0;
        step();
    endtask

    // Scoreboard: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (core_valid || host_ack)) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_owner", 32'({host_ack, core_valid}), 32'({e.host, !e.host}));
                if (e.chk) chk("sb_rdata", 32'(e.host ? host_rdata : core_rdata), 32'(e.data));
            end
        end
    end

    logic [DW-1:0] pv [4];

    initial begin
        pv = '{8'h2B, 8'h3C, 8'h4D, 8'h5E};
        rst = 1; clr_core(); core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_space = 0; host_addr = 0; host_wdata = 0;
        io_out_ready = 0; io_in_data = 0; io_in_valid = 0;
        // Requests held during reset must not leak onto the bus.
        read_prog = 1; host_req = 1;
        step(); step(); #1;
        chk("rst_mem_en",  32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_valids",  32'({core_valid, host_ack, io_out_valid, io_in_ready}), 0);
        chk("rst_busy_err", 32'({busy, bus_err}), 0);
        chk("rst_data",    32'({core_rdata, host_rdata, io_out_data}), 0);
        clr_core(); host_req = 0; rst = 0;
        step();

        // Host write at the top of data space.
        push(1'b1, 1'b0, 8'h00);
        host_req = 1; host_we = 1; host_space = 1; host_addr = 15'h7FFF; host_wdata = 8'hA5;
        #1;
        chk("t6_mem_addr", 32'(mem_addr), 32'h0000FFFF);
        chk("t6_mem_we", 32'({mem_en, mem_we}), 32'd3);
        chk("t6_mem_wdata", 32'(mem_wdata), 32'hA5);
        step();
        chk("t6_ack", 32'(host_ack), 1);
        host_req = 0;
        step();
        chk("t6_idle", 32'(busy), 0);
        core_op(5'b00010, 15'h7FFF, 8'h00, 1'b1, 8'hA5, "t6_rd");

        // Preload program bytes and data[3] through the host port.
        for (int i = 0; i < 4; i++) host_op(1'b1, 1'b0, 15'(16 + i), pv[i], 1'b0, 8'h00, "pre_prog");
        host_op(1'b1, 1'b1, 15'h0003, 8'h77, 1'b0, 8'h00, "pre_data");

        // Core program read: address in grant cycle, valid two cycles later.
        push(1'b0, 1'b1, 8'h2B);
        read_prog = 1; core_addr = 15'h0010;
        #1;
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_mem_en", 32'({mem_en, mem_we}), 32'd2);
        step();
        chk("t1_wait", 32'(core_valid), 0);
        step();
        chk("t1_valid", 32'(core_valid), 1);
        chk("t1_rdata", 32'(core_rdata), 32'h2B);
        clr_core();
        step();
        chk("t1_idle", 32'(busy), 0);

        // Fresh reset: host wins the first tie, then grants alternate.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 1'b1, pv[i]);
            push(1'b0, 1'b0, 8'h00);
        end
        host_req = 1; host_we = 0; host_space = 0; host_addr = 15'h0010;
        write_data = 1; core_addr = 15'h0020; core_wdata = 8'h60;
        #1;
        chk("t2_first_host", 32'({mem_en, mem_we, mem_addr}), 32'h20010);
        begin
            int hc = 0, cc = 0, n = 0;
            while ((hc < 4 || cc < 4) && n < 100) begin
                step(); n++;
                if (host_ack) begin
                    hc++;
                    if (hc < 4) host_addr = 15'(16 + hc); else host_req = 0;
                end
                if (core_valid) begin
                    cc++;
                    if (cc < 4) begin core_addr = 15'(32 + cc); core_wdata = 8'(96 + cc); end
                    else write_data = 0;
                end
            end
            chk("t2_pairs", 32'({hc[7:0], cc[7:0]}), 32'h0404);
        end
        step();
        chk("t2_sb_empty", 32'(sb.size()), 0);
        for (int i = 0; i < 4; i++) core_op(5'b00010, 15'(32 + i), 8'h00, 1'b1, 8'(96 + i), "t2_readback");

        // Output byte held stable while the sink stalls.
        push(1'b0, 1'b0, 8'h00);
        write_io = 1; core_wdata = 8'h41;
        step();
        core_wdata = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("t3_out_valid", 32'(io_out_valid), 1);
            chk("t3_out_data", 32'(io_out_data), 32'h41);
            chk("t3_no_valid", 32'(core_valid), 0);
            step();
        end
        io_out_ready = 1;
        step();
        chk("t3_valid", 32'(core_valid), 1);
        chk("t3_out_drop", 32'(io_out_valid), 0);
        io_out_ready = 0; clr_core();
        step();

        // Conflicting strobes: read wins, bus_err sticks.
        push(1'b0, 1'b1, 8'h77);
        read_data = 1; write_data = 1; core_addr = 15'h0003; core_wdata = 8'h99;
        #1;
        chk("t4_mem", 32'({mem_en, mem_we, mem_addr}), 32'h28003);
        wait_done(1'b0, "t4_done");
        clr_core();
        step();
        chk("t4_bus_err", 32'(bus_err), 1);
        core_op(5'b00010, 15'h0003, 8'h00, 1'b1, 8'h77, "t4_readback");
        chk("t4_err_sticky", 32'(bus_err), 1);

        // Reset while waiting for an input byte.
        read_io = 1;
        step();
        chk("t5_in_ready", 32'(io_in_ready), 1);
        step();
        rst = 1; clr_core();
        step();
        rst = 0;
        chk("t5_ready_clr", 32'(io_in_ready), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_err_clr", 32'(bus_err), 0);
        io_in_valid = 1; io_in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_byte_waits", 32'({io_in_ready, core_rdata}), 0);
        end
        core_op(5'b01000, 15'h0000, 8'h00, 1'b1, 8'h55, "t5_read_io");
        io_in_valid = 0;
        step();
        chk("end_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
